instruction_prefetch_queue: RTL and testbench



---
 rtl/pa_riscv.sv | 13 +
 rtl/prefetchFifo.sv | 55 +++++
 rtl/instruction_prefetch_queue.sv | 110 +++++++++++
 tb/tb_instruction_prefetch_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pa_riscv.sv
// Shared fetch-path types and constants for the instruction prefetch queue.
// Types and constants only, so there is no latency and no backpressure.
package pa_riscv;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES      = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetchEntry_t;

endpackage

// File: rtl/prefetchFifo.sv
// Generic synchronous FIFO with a registered storage array. Data pushed in cycle N is at the head in N+1.
// Flush empties it in one cycle. No internal backpressure: the caller must never push when full without also popping.
module prefetchFifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic [63:0]
) (
  input  logic                     i_clk,
  input  logic                     i_srst,
  input  logic                     i_push,
  input  entry_t                   i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output entry_t                   o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  // The extra pointer MSB tells full from empty when the index bits match.
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_count = wr_ptr_q - rd_ptr_q;
  assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (i_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (i_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (i_push && !i_flush) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/instruction_prefetch_queue.sv
// In-order instruction prefetcher with credit-limited memory requests, redirect flush and a DEPTH-entry queue. Response-to-valid is 1 cycle, or 0 with PREFETCH_BYPASS_EN.
// Backpressure: the core stalls via i_instrReady, and requests stop once queued + in-flight + discarded reaches DEPTH.
module instruction_prefetch_queue
  import pa_riscv::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_srst,
  output logic        o_memReq,
  output logic [31:0] o_memAddr,
  input  logic        i_memGnt,
  input  logic        i_memRvalid,
  input  logic [31:0] i_memRdata,
  output logic        o_instrValid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instrPc,
  input  logic        i_instrReady,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [31:0] PC_STEP = 32'(INSTR_BYTES);

  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d, fifo_count;
  logic [CW+1:0] credit_used;
  logic          grant, resp_live, bypass, bypass_take, push, pop;
  logic          fifo_empty, fifo_full, unused_redirect_lsbs;
  fetchEntry_t   head, resp_entry;

  assign unused_redirect_lsbs = ^i_redirectPc[1:0];

  assign credit_used = (CW+2)'(fifo_count) + (CW+2)'(inflight_q) + (CW+2)'(discard_q);
  assign o_memReq    = !i_srst && (credit_used < (CW+2)'(DEPTH));
  assign o_memAddr   = fetch_pc_q;
  assign grant       = o_memReq && i_memGnt;
  assign resp_live   = i_memRvalid && (discard_q == '0);
  assign resp_entry  = '{instr: i_memRdata, pc: resp_pc_q};

`ifdef PREFETCH_BYPASS_EN
  assign bypass = fifo_empty && resp_live && !i_redirect;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that the core takes immediately never enters the queue.
  assign bypass_take  = bypass && i_instrReady;
  assign o_instrValid = !i_redirect && (!fifo_empty || bypass);
  assign o_instr      = bypass ? i_memRdata : head.instr;
  assign o_instrPc    = bypass ? resp_pc_q  : head.pc;
  assign push         = resp_live && !i_redirect && !bypass_take;
  assign pop          = !fifo_empty && !i_redirect && i_instrReady;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (i_redirect) begin
      fetch_pc_d = {i_redirectPc[31:2], 2'b00};
      resp_pc_d  = {i_redirectPc[31:2], 2'b00};
      inflight_d = '0;
      discard_d  = discard_q + inflight_q + CW'(grant) - CW'(i_memRvalid);
    end else begin
      if (grant)     fetch_pc_d = fetch_pc_q + PC_STEP;
      if (resp_live) resp_pc_d  = resp_pc_q + PC_STEP;
      inflight_d = inflight_q + CW'(grant) - CW'(resp_live);
      if (i_memRvalid && !resp_live) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  prefetchFifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetchEntry_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_srst  (i_srst),
    .i_push  (push),
    .i_data  (resp_entry),
    .i_pop   (pop),
    .i_flush (i_redirect),
    .o_data  (head),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_count (fifo_count)
  );

  a_resp_has_owner: assert property (@(posedge i_clk) disable iff (i_srst)
    i_memRvalid |-> (inflight_q != '0 || discard_q != '0));
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_srst)
    !(fifo_full && push && !pop));

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Scoreboarded bench: directed phases queue expected PCs, a monitor checks every core handshake.
// A small in-order memory model answers each grant after mem_lat cycles with word_at(addr).
module tb_instruction_prefetch_queue;

  logic        i_clk = 1'b0;
  logic        i_srst = 1'b1;
  logic        i_memGnt = 1'b1;
  logic        i_memRvalid = 1'b0;
  logic [31:0] i_memRdata = '0;
  logic        i_instrReady = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirectPc = '0;
  logic        o_memReq, o_instrValid;
  logic [31:0] o_memAddr, o_instr, o_instrPc;

  int          checks_total = 0;
  int          checks_passed = 0;
  int          mem_lat = 1;
  logic [31:0] exp_q[$];

`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  instruction_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .i_clk        (i_clk),
    .i_srst       (i_srst),
    .o_memReq     (o_memReq),
    .o_memAddr    (o_memAddr),
    .i_memGnt     (i_memGnt),
    .i_memRvalid  (i_memRvalid),
    .i_memRdata   (i_memRdata),
    .o_instrValid (o_instrValid),
    .o_instr      (o_instr),
    .o_instrPc    (o_instrPc),
    .i_instrReady (i_instrReady),
    .i_redirect   (i_redirect),
    .i_redirectPc (i_redirectPc)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic consume_all(input int budget);
    i_instrReady = 1'b1;
    for (int n = 0; n < budget && exp_q.size() != 0; n++) tick();
    i_instrReady = 1'b0;
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset(input int lat);
    i_srst       = 1'b1;
    i_redirect   = 1'b0;
    i_instrReady = 1'b0;
    mem_lat      = lat;
    repeat (3) tick();
    i_srst = 1'b0;
    #1;
  endtask

  // Memory: sample the grant mid-cycle, answer mem_lat cycles later.
  initial begin
    bit          pv [4];
    logic [31:0] pd [4];
    bit          g;
    logic [31:0] a;
    for (int k = 0; k < 4; k++) begin pv[k] = 1'b0; pd[k] = '0; end
    forever begin
      @(negedge i_clk);
      g = o_memReq && i_memGnt;
      a = o_memAddr;
      @(posedge i_clk);
      #1;
      for (int k = 3; k > 0; k--) begin pv[k] = pv[k-1]; pd[k] = pd[k-1]; end
      pv[0] = g;
      pd[0] = word_at(a);
      i_memRvalid = pv[mem_lat-1];
      i_memRdata  = pv[mem_lat-1] ? pd[mem_lat-1] : 32'h0;
    end
  end

  // Monitor: every core handshake must match the head of the expected queue.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge i_clk);
      if (o_instrValid && i_instrReady) begin
        if (exp_q.size() == 0) begin
          checks_total++;
          $display("FAIL unexpected_pop: got pc %h, expected no handshake", o_instrPc);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", o_instrPc, e);
          check("pop_instr", o_instr, word_at(e));
        end
      end
    end
  end

  initial begin
    // Reset values while reset is held.
    repeat (3) tick();
    #1;
    check("rst_memReq", o_memReq, 0);
    check("rst_instrValid", o_instrValid, 0);
    check("rst_memAddr", o_memAddr, 32'h0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_instrPc", o_instrPc, 32'h0);

    // Streaming at latency 1, core always ready.
    tick();
    i_srst = 1'b0;
    i_instrReady = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
    #1;
    check("c0_memReq", o_memReq, 1);
    check("c0_memAddr", o_memAddr, 32'h0);
    check("c0_valid", o_instrValid, 0);
    tick(); #1;
    check("c1_memAddr", o_memAddr, 32'h4);
    check("c1_valid", o_instrValid, 32'(BYP));
    tick(); #1;
    check("c2_memAddr", o_memAddr, 32'h8);
    check("c2_valid", o_instrValid, 1);
    check("c2_pc", o_instrPc, BYP ? 32'h4 : 32'h0);
    consume_all(40);

    // Backpressure: four grants, then requests stop.
    do_reset(1);
    for (int c = 0; c < 10; c++) begin
      check("bp_memReq", o_memReq, 32'(c < 4));
      if (c == 4) check("bp_memAddr", o_memAddr, 32'h10);
      tick(); #1;
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
    consume_all(60);

    // Reset with 3 queued and 1 in flight.
    do_reset(1);
    repeat (4) tick();
    i_srst = 1'b1;
    tick(); #1;
    check("mr_valid", o_instrValid, 0);
    check("mr_memReq", o_memReq, 0);
    check("mr_memAddr", o_memAddr, 32'h0);
    check("mr_instrPc", o_instrPc, 32'h0);
    i_srst = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(4 * k));
    #1;
    check("mr_restart_req", o_memReq, 1);
    check("mr_restart_addr", o_memAddr, 32'h0);
    consume_all(40);

    // Redirect with 2 queued and 2 in flight at latency 2.
    do_reset(2);
    repeat (4) tick();
    i_redirect   = 1'b1;
    i_redirectPc = 32'h0000_0100;
    i_instrReady = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h100 + 32'(4 * k));
    #1;
    check("rd_valid_masked", o_instrValid, 0);
    check("rd_memReq_full", o_memReq, 0);
    tick();
    i_redirect = 1'b0;
    #1;
    check("rd_next_req", o_memReq, 1);
    check("rd_next_addr", o_memAddr, 32'h100);
    check("rd_next_valid", o_instrValid, 0);
    consume_all(40);

    // Misaligned redirect near the top of the address space, issued alongside a grant.
    do_reset(1);
    i_redirect   = 1'b1;
    i_redirectPc = 32'hFFFF_FFFE;
    #1;
    check("wr_old_req", o_memReq, 1);
    check("wr_old_addr", o_memAddr, 32'h0);
    tick();
    i_redirect = 1'b0;
    i_instrReady = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    #1;
    check("wr_aligned_addr", o_memAddr, 32'hFFFF_FFFC);
    check("wr_aligned_req", o_memReq, 1);
    tick(); #1;
    check("wr_wrap_addr", o_memAddr, 32'h0);
    consume_all(40);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
